// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq: walks a fixed WM8731 register table and hands each write to the
// I2C master as a 24-bit frame over valid/ready. It waits for the master's
// completion status, resends NACKed frames a bounded number of times, and
// spaces successive good frames by a fixed idle gap.
module codec_cfg_seq #(
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter int unsigned NUM_REGS   = 10,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned GAP_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        key,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [23:0] cmd_word,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [3:0]  cfg_idx
);

  localparam int unsigned IDX_W   = 4;
  localparam int unsigned WORD_W  = 24;
  localparam int unsigned ENTRY_W = 16;
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int unsigned GAP_W   = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_GAP       = 3'd3,
    S_DONE      = 3'd4,
    S_ERROR     = 3'd5
  } state_e;

  // Register table: {reg_addr[6:0], reg_data[8:0]}. The activation write
  // (0x09,0x001) is forced into entry 9 for the default 10-entry sequence so
  // it is always the final frame.
  function automatic logic [ENTRY_W-1:0] table_entry(input logic [IDX_W-1:0] idx);
    logic [6:0] addr;
    logic [8:0] data;
    addr = 7'h09;
    data = 9'h001;
    case (idx)
      4'd0: begin addr = 7'h0F; data = 9'h000; end
      4'd1: begin addr = 7'h00; data = 9'h017; end
      4'd2: begin addr = 7'h01; data = 9'h017; end
      4'd3: begin addr = 7'h02; data = 9'h079; end
      4'd4: begin addr = 7'h03; data = 9'h079; end
      4'd5: begin addr = 7'h04; data = 9'h012; end
      4'd6: begin addr = 7'h05; data = 9'h000; end
      4'd7: begin addr = 7'h06; data = 9'h000; end
      4'd8: begin addr = 7'h07; data = 9'h002; end
      4'd9: begin
        if (NUM_REGS == 10) begin
          addr = 7'h09; data = 9'h001;
        end else begin
          addr = 7'h08; data = 9'h000;
        end
      end
      default: begin addr = 7'h09; data = 9'h001; end
    endcase
    return {addr, data};
  endfunction

  // Full I2C frame: write address byte followed by the register entry.
  function automatic logic [WORD_W-1:0] frame_word(input logic [IDX_W-1:0] idx);
    return {DEV_ADDR, 1'b0, table_entry(idx)};
  endfunction

  // Start-button synchroniser, edge history and registered start pulse.
  logic key_s1_q, key_s1_d;
  logic key_s2_q, key_s2_d;
  logic key_s3_q, key_s3_d;
  logic start_q,  start_d;

  // Sequencer state and registered outputs.
  state_e              state_q,     state_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [WORD_W-1:0]   cmd_word_q,  cmd_word_d;
  logic                busy_q,      busy_d;
  logic                cfg_done_q,  cfg_done_d;
  logic                cfg_err_q,   cfg_err_d;
  logic [IDX_W-1:0]    cfg_idx_q,   cfg_idx_d;
  logic [RETRY_W-1:0]  retry_q,     retry_d;
  logic [GAP_W-1:0]    gap_q,       gap_d;

  logic key_fall;
  logic accept;

  // Synchroniser shift and falling-edge detect on the active-low key.
  always_comb begin
    key_s1_d = key;
    key_s2_d = key_s1_q;
    key_s3_d = key_s2_q;
    key_fall = key_s3_q & ~key_s2_q;
    start_d  = key_fall;
  end

  assign accept = cmd_valid_q & cmd_ready;

  // Next-state and output decode for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_word_d  = cmd_word_q;
    busy_d      = busy_q;
    cfg_done_d  = cfg_done_q;
    cfg_err_d   = cfg_err_q;
    cfg_idx_d   = cfg_idx_q;
    retry_d     = retry_q;
    gap_d       = gap_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_q) begin
          state_d     = S_SEND;
          cmd_valid_d = 1'b1;
          cmd_word_d  = frame_word('0);
          busy_d      = 1'b1;
          cfg_done_d  = 1'b0;
          cfg_err_d   = 1'b0;
          cfg_idx_d   = '0;
          retry_d     = '0;
        end
      end

      S_SEND: begin
        if (accept) begin
          cmd_valid_d = 1'b0;
          state_d     = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (i2c_done) begin
          if (!i2c_nack) begin
            retry_d = '0;
            if (cfg_idx_q == LAST_IDX) begin
              state_d    = S_DONE;
              cfg_done_d = 1'b1;
              busy_d     = 1'b0;
            end else begin
              state_d = S_GAP;
              gap_d   = GAP_LOAD;
            end
          end else if (retry_q < RETRY_MAX) begin
            // Resend the same word; cmd_word_q is left untouched.
            retry_d     = retry_q + RETRY_W'(1);
            state_d     = S_SEND;
            cmd_valid_d = 1'b1;
          end else begin
            state_d   = S_ERROR;
            cfg_err_d = 1'b1;
            busy_d    = 1'b0;
          end
        end
      end

      S_GAP: begin
        // Count down to zero so valid rises GAP_CYCLES+1 edges after done.
        if (gap_q == '0) begin
          state_d     = S_SEND;
          cfg_idx_d   = cfg_idx_q + IDX_W'(1);
          cmd_word_d  = frame_word(cfg_idx_q + IDX_W'(1));
          cmd_valid_d = 1'b1;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // All state and output flops, cleared asynchronously by reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_s1_q    <= 1'b1;
      key_s2_q    <= 1'b1;
      key_s3_q    <= 1'b1;
      start_q     <= 1'b0;
      state_q     <= S_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_word_q  <= '0;
      busy_q      <= 1'b0;
      cfg_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      cfg_idx_q   <= '0;
      retry_q     <= '0;
      gap_q       <= '0;
    end else begin
      key_s1_q    <= key_s1_d;
      key_s2_q    <= key_s2_d;
      key_s3_q    <= key_s3_d;
      start_q     <= start_d;
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_word_q  <= cmd_word_d;
      busy_q      <= busy_d;
      cfg_done_q  <= cfg_done_d;
      cfg_err_q   <= cfg_err_d;
      cfg_idx_q   <= cfg_idx_d;
      retry_q     <= retry_d;
      gap_q       <= gap_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_word  = cmd_word_q;
  assign busy      = busy_q;
  assign cfg_done  = cfg_done_q;
  assign cfg_err   = cfg_err_q;
  assign cfg_idx   = cfg_idx_q;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Bench for codec_cfg_seq: behavioural I2C master model, scenario table for the
// full-sequence runs, and hand-written sequences for stall, ignored start,
// restart and mid-gap reset.
module tb_codec_cfg_seq;

  localparam int unsigned GAP       = 64;
  localparam int unsigned NREG      = 10;
  localparam int unsigned MAX_RETRY = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        key;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_word;
  logic        i2c_done;
  logic        i2c_nack;
  logic        busy;
  logic        cfg_done;
  logic        cfg_err;
  logic [3:0]  cfg_idx;

  codec_cfg_seq #(
    .DEV_ADDR  (7'h1A),
    .NUM_REGS  (NREG),
    .MAX_RETRY (MAX_RETRY),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .key      (key),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_word (cmd_word),
    .i2c_done (i2c_done),
    .i2c_nack (i2c_nack),
    .busy     (busy),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .cfg_idx  (cfg_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Expected frames, hand-computed as {8'h34, addr[6:0], data[8:0]}.
  logic [23:0] exp_tab [10] = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
                                24'h340812, 24'h340A00, 24'h340C00, 24'h340E02, 24'h341201};

  // Master model state.
  logic [23:0] log_q [$];
  int          gap_q [$];
  int          nack_left [16];
  int          done_dly;
  bit          pending;
  int          dly_cnt;
  bit          have_done;
  int          last_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // I2C master: logs accepted frames, returns done (and scripted nack) done_dly edges later.
  initial begin
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    pending  = 1'b0;
    dly_cnt  = 0;
    forever begin
      @(negedge clk);
      #2;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (!reset_n) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          dly_cnt--;
          if (dly_cnt == 0) begin
            pending  = 1'b0;
            i2c_done = 1'b1;
            if (nack_left[cfg_idx] > 0) begin
              i2c_nack = 1'b1;
              nack_left[cfg_idx]--;
            end
            last_done = cyc + 1;
            have_done = 1'b1;
          end
        end
        if (cmd_valid && cmd_ready) begin
          log_q.push_back(cmd_word);
          if (have_done) gap_q.push_back(cyc + 1 - last_done);
          pending = 1'b1;
          dly_cnt = done_dly;
        end
      end
    end
  end

  task automatic clear_model();
    log_q.delete();
    gap_q.delete();
    have_done = 1'b0;
    for (int i = 0; i < 16; i++) nack_left[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    key       = 1'b1;
    cmd_ready = 1'b1;
    done_dly  = 5;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_word",  32'(cmd_word),  32'd0);
    chk("rst_flags", 32'({busy, cfg_done, cfg_err}), 32'd0);
    chk("rst_idx",   32'(cfg_idx),   32'd0);
    clear_model();
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Key low for 10 cycles; optionally checks start latency and start-of-run state.
  task automatic press(input bit chk_lat);
    @(negedge clk);
    key = 1'b0;
    repeat (3) @(negedge clk);
    if (chk_lat) chk("valid_before_n3", 32'(cmd_valid), 32'd0);
    @(negedge clk);
    if (chk_lat) begin
      chk("valid_at_n3", 32'(cmd_valid), 32'd1);
      chk("start_flags", 32'({busy, cfg_done, cfg_err}), 32'b100);
      chk("start_idx",   32'(cfg_idx),  32'd0);
      chk("start_word",  32'(cmd_word), 32'(exp_tab[0]));
    end
    repeat (6) @(negedge clk);
    key = 1'b1;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!(!busy && (cfg_done || cfg_err)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("end_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_log(input int cnt, input int budget);
    int n;
    n = 0;
    while (log_q.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("log_timeout", 32'(n < budget), 32'd1);
  endtask

  typedef struct {
    string      name;
    int         nack_idx;
    int         nack_cnt;
    int         exp_frames;
    logic       exp_done;
    logic       exp_err;
    logic [3:0] exp_idx;
  } scen_t;

  scen_t       sc [3];
  logic [23:0] exp_q [$];
  int          bad;
  logic [23:0] held;

  initial begin
    reset_n   = 1'b0;
    key       = 1'b1;
    cmd_ready = 1'b1;
    done_dly  = 5;
    clear_model();

    sc[0] = '{"all_ack",   0, 0,  10, 1'b1, 1'b0, 4'd9};
    sc[1] = '{"nack_f3x2", 3, 2,  12, 1'b1, 1'b0, 4'd9};
    sc[2] = '{"nack_f0",   0, 99,  4, 1'b0, 1'b1, 4'd0};

    // Full-sequence runs with scripted NACKs.
    for (int s = 0; s < 3; s++) begin
      do_reset();
      nack_left[sc[s].nack_idx] = sc[s].nack_cnt;
      press(1'b1);
      wait_end(5000);
      chk({sc[s].name, "_done"},  32'(cfg_done),  32'(sc[s].exp_done));
      chk({sc[s].name, "_err"},   32'(cfg_err),   32'(sc[s].exp_err));
      chk({sc[s].name, "_idx"},   32'(cfg_idx),   32'(sc[s].exp_idx));
      chk({sc[s].name, "_idle"},  32'({busy, cmd_valid}), 32'd0);
      chk({sc[s].name, "_count"}, 32'(log_q.size()), 32'(sc[s].exp_frames));
      exp_q.delete();
      for (int i = 0; i < int'(NREG); i++) begin
        int n;
        n = (i == sc[s].nack_idx) ? sc[s].nack_cnt + 1 : 1;
        if (n > int'(MAX_RETRY) + 1) begin
          for (int k = 0; k <= int'(MAX_RETRY); k++) exp_q.push_back(exp_tab[i]);
          break;
        end
        for (int k = 0; k < n; k++) exp_q.push_back(exp_tab[i]);
      end
      for (int k = 0; k < log_q.size() && k < exp_q.size(); k++)
        chk({sc[s].name, "_frame"}, 32'(log_q[k]), 32'(exp_q[k]));
      if (sc[s].nack_cnt == 0) begin
        chk("gap_count", 32'(gap_q.size()), 32'(NREG - 1));
        foreach (gap_q[k]) chk("gap_len", 32'(gap_q[k]), 32'(GAP + 2));
      end
    end

    // Back-pressure: valid and word held while ready is low, accept on first ready.
    do_reset();
    cmd_ready = 1'b0;
    press(1'b1);
    held = cmd_word;
    bad  = 0;
    repeat (50) begin
      @(negedge clk);
      if (!cmd_valid || cmd_word !== held) bad++;
    end
    chk("stall_stable", 32'(bad), 32'd0);
    chk("stall_word",   32'(held), 32'(exp_tab[0]));
    chk("stall_nolog",  32'(log_q.size()), 32'd0);
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("stall_accept_valid", 32'(cmd_valid), 32'd0);
    @(negedge clk);
    chk("stall_accept_log", 32'(log_q.size()), 32'd1);
    wait_end(5000);
    chk("stall_done", 32'(cfg_done), 32'd1);

    // Start during WAIT_DONE of frame 4 is ignored; start after DONE restarts.
    do_reset();
    done_dly = 20;
    press(1'b1);
    wait_log(5, 5000);
    chk("ign_in_wait", 32'({cmd_valid, busy, cfg_idx}), 32'({1'b0, 1'b1, 4'd4}));
    press(1'b0);
    wait_end(5000);
    chk("ign_count", 32'(log_q.size()), 32'd10);
    chk("ign_first", 32'(log_q[0]), 32'(exp_tab[0]));
    chk("ign_f5",    32'(log_q[5]), 32'(exp_tab[5]));
    chk("ign_done",  32'({cfg_done, cfg_idx}), 32'({1'b1, 4'd9}));
    clear_model();
    press(1'b1);
    wait_end(5000);
    chk("restart_count", 32'(log_q.size()), 32'd10);
    chk("restart_last",  32'(log_q[9]), 32'(exp_tab[9]));
    chk("restart_done",  32'(cfg_done), 32'd1);

    // Asynchronous reset while in the gap after frame 6.
    do_reset();
    press(1'b1);
    wait_log(7, 5000);
    begin
      int n;
      n = 0;
      while ((pending || cmd_valid) && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("gap6_reach", 32'(n < 100), 32'd1);
    end
    repeat (10) @(negedge clk);
    chk("gap6_state", 32'({busy, cmd_valid, cfg_idx}), 32'({1'b1, 1'b0, 4'd6}));
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_outs", 32'({cmd_valid, busy, cfg_done, cfg_err, cfg_idx}), 32'd0);
    chk("async_rst_word", 32'(cmd_word), 32'd0);
    @(negedge clk);
    clear_model();
    reset_n = 1'b1;
    @(negedge clk);
    press(1'b1);
    wait_end(5000);
    chk("post_rst_first", 32'(log_q[0]), 32'(exp_tab[0]));
    chk("post_rst_done",  32'({cfg_done, cfg_err, cfg_idx}), 32'({1'b1, 1'b0, 4'd9}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
